// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// a helper for sizing the bit counter.
package serial_add_sub_pkg;

    // Control FSM encoding: IDLE -> SHIFT -> DONE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Width of the bit counter; never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_fulladder.sv
// Team 1-bit full-adder cell. Purely combinational; used once per clock by
// the serial datapath.
module Fulladder
    import serial_add_sub_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor. Operands are captured on a
// start request, then one result bit per clock is produced LSB first by the
// Fulladder cell; the finished result is published with a one-cycle done.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sha_q, sha_d;
    logic [WIDTH-1:0]   shb_q, shb_d;
    logic [WIDTH-1:0]   shr_q, shr_d;
    logic               cff_q, cff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               v_q, v_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_s;
    logic               fa_co;

    // Single full-adder cell fed from the LSBs of the operand shifters
    Fulladder u_fa (
        .A  (sha_q[0]),
        .B  (shb_q[0]),
        .Ci (cff_q),
        .S  (fa_s),
        .Co (fa_co)
    );

    // Next-state, datapath and output-register logic for the control FSM
    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shr_d   = shr_q;
        cff_d   = cff_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        v_d     = v_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and preload carry
                    sha_d   = A;
                    shb_d   = sub ? ~B : B;
                    cff_d   = sub;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shr_d = {fa_s, shr_q[WIDTH-1:1]};
                sha_d = {1'b0, sha_q[WIDTH-1:1]};
                shb_d = {1'b0, shb_q[WIDTH-1:1]};
                cff_d = fa_co;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: cff still holds the carry into the MSB
                    s_d     = {fa_s, shr_q[WIDTH-1:1]};
                    co_d    = fa_co;
                    v_d     = cff_q ^ fa_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sha_q   <= {WIDTH{1'b0}};
            shb_q   <= {WIDTH{1'b0}};
            shr_q   <= {WIDTH{1'b0}};
            cff_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            s_q     <= {WIDTH{1'b0}};
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shr_q   <= shr_d;
            cff_q   <= cff_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Co   = co_q;
    assign V    = v_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed cases, random
// operations against an arithmetic reference model, start-while-busy,
// mid-operation reset and back-to-back operation.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Co;
    logic         V;

    int tests_run;
    int tests_failed;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Co    (Co),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, output logic [W-1:0] rs,
                                  output logic rco, output logic rv);
        int sa;
        int sb;
        int r;
        sa  = $signed(a);
        sb  = $signed(b);
        r   = s ? (sa - sb) : (sa + sb);
        rv  = (r > 127) || (r < -128);
        rs  = s ? (a - b) : (a + b);
        rco = s ? (a >= b) : ((int'(a) + int'(b)) > 255);
    endfunction

    // Run one operation; returns edges from E0 to done (E0 counted), the
    // captured result, and done as seen one cycle later. Inputs are
    // scrambled right after E0.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output logic [W-1:0] rs, output logic rco,
                         output logic rv, output logic done_next);
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
        while (done !== 1'b1 && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = S; rco = Co; rv = V;
        @(negedge clk);
        done_next = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, S, Co, V} !== {2'b00, 8'h00, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b S=%h Co=%b V=%b, need all 0", busy, done, S, Co, V);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic s);
        int lat;
        logic [W-1:0] rs, es;
        logic rco, rv, dn, eco, ev;
        model(a, b, s, es, eco, ev);
        do_op(a, b, s, lat, rs, rco, rv, dn);
        tests_run++;
        if (rs !== es || rco !== eco || rv !== ev) begin
            tests_failed++;
            $display("FAIL %s result (%h %s %h): got S=%h Co=%b V=%b, need S=%h Co=%b V=%b",
                     name, a, s ? "-" : "+", b, rs, rco, rv, es, eco, ev);
        end
        tests_run++;
        if (lat !== 9 || dn !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s timing: latency=%0d done_next=%b, need 9 and 0", name, lat, dn);
        end
    endtask

    task automatic test_directed();
        check_op("add_25_17",   8'd25,  8'd17,  1'b0);
        check_op("sub_5_7",     8'd5,   8'd7,   1'b1);
        check_op("sub_7_5",     8'd7,   8'd5,   1'b1);
        check_op("add_7f_01",   8'h7F,  8'h01,  1'b0);
        check_op("add_ff_01",   8'hFF,  8'h01,  1'b0);
        check_op("sub_80_01",   8'h80,  8'h01,  1'b1);
        check_op("sub_x_0",     8'h3C,  8'h00,  1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_op("random", W'($urandom), W'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_start_while_busy();
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [W-1:0] rs;
        busy_cnt = 0; done_cnt = 0; done_at = 0; rs = '0;
        @(negedge clk);
        A = 8'd10; B = 8'd3; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1; A = 8'd99; B = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
                rs = S;
            end
            if (busy !== 1'b1) break;
        end
        tests_run++;
        if (rs !== 8'd13 || done_cnt !== 1 || done_at !== 9) begin
            tests_failed++;
            $display("FAIL ignore_start: S=%0d dones=%0d at=%0d, need S=13 dones=1 at=9", rs, done_cnt, done_at);
        end
        tests_run++;
        if (busy_cnt !== 9) begin
            tests_failed++;
            $display("FAIL busy_len: got %0d cycles, need 9", busy_cnt);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start_idle: busy=%b, need 0", busy);
        end
    endtask

    task automatic test_reset_midop();
        int seen_done;
        int lat;
        logic [W-1:0] rs;
        logic rco, rv, dn;
        seen_done = 0;
        @(negedge clk);
        A = 8'h55; B = 8'h0F; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, S, Co, V} !== {2'b00, 8'h00, 2'b00}) begin
            tests_failed++;
            $display("FAIL midop_reset: busy=%b done=%b S=%h Co=%b V=%b, need all 0", busy, done, S, Co, V);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin
            tests_failed++;
            $display("FAIL midop_no_done: saw activity in %0d cycles, need 0", seen_done);
        end
        do_op(8'd1, 8'd1, 1'b0, lat, rs, rco, rv, dn);
        tests_run++;
        if (rs !== 8'd2 || rco !== 1'b0 || rv !== 1'b0 || lat !== 9) begin
            tests_failed++;
            $display("FAIL after_reset: S=%0d Co=%b V=%b lat=%0d, need S=2 Co=0 V=0 lat=9", rs, rco, rv, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [5];
        logic [W-1:0] ob [5];
        logic         os [5];
        logic [W-1:0] es;
        logic eco, ev;
        int cyc;
        int last_done;
        int j;
        for (int k = 0; k < 5; k++) begin
            oa[k] = W'($urandom); ob[k] = W'($urandom); os[k] = 1'($urandom);
        end
        repeat (2) @(negedge clk);
        A = oa[0]; B = ob[0]; sub = os[0]; start = 1'b1;
        cyc = 0; last_done = 0; j = 0;
        while (j < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                model(oa[j], ob[j], os[j], es, eco, ev);
                tests_run++;
                if (S !== es || Co !== eco || V !== ev) begin
                    tests_failed++;
                    $display("FAIL b2b_result[%0d]: got S=%h Co=%b V=%b, need S=%h Co=%b V=%b",
                             j, S, Co, V, es, eco, ev);
                end
                tests_run++;
                if ((j == 0 && cyc !== 9) || (j > 0 && cyc - last_done !== 10)) begin
                    tests_failed++;
                    $display("FAIL b2b_spacing[%0d]: done at cycle %0d, previous %0d", j, cyc, last_done);
                end
                last_done = cyc;
                j++;
                if (j < 5) begin
                    A = oa[j]; B = ob[j]; sub = os[j];
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (j !== 5) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results, need 5", j);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
